// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution (pass / Sobel / Gaussian / thresholded Sobel) over a raster pixel stream.
// Latency: result registered one clk after the pixel that completes a 3x3 window is accepted.
// Backpressure: none; validData=0 stalls every counter, buffer and window register.
// Optional macro CONV3X3_SAT_COUNT_EN adds a 16-bit saturating count of clamped Sobel results (sat_count).
module conv3x3_stream #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int THRESH = 128,
    localparam int NRES   = (IMG_W - 2) * (IMG_H - 2),
    localparam int ADDR_W = (NRES > 1) ? $clog2(NRES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        filter,
    input  logic              validData,
    input  logic [PIX_W-1:0]  pixel_in,
    output logic              ValidResult,
    output logic [ADDR_W-1:0] Pixel_address,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              busy,
    output logic              done
`ifdef CONV3X3_SAT_COUNT_EN
    ,
    output logic [15:0]       sat_count
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SW = PIX_W + 2;   // one Sobel half-sum: up to 4 * max pixel
    localparam int MW = PIX_W + 3;   // |Gx| + |Gy|
    localparam int GW = PIX_W + 4;   // Gaussian weighted sum: up to 16 * max pixel

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [ADDR_W-1:0]   r_oidx;
    logic [1:0]          r_mode;
    logic                r_vld;
    logic [PIX_W-1:0]    r_pout;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_busy;
    logic                r_done;

    // Two previous image rows; r_lb1 holds row-1, r_lb2 holds row-2.
    logic [PIX_W-1:0]    r_lb1 [IMG_W];
    logic [PIX_W-1:0]    r_lb2 [IMG_W];
    // Stored window columns [row][age]: age 0 = previous column, age 1 = the one before.
    // The newest column comes straight from the line buffers and pixel_in.
    logic [PIX_W-1:0]    r_win [3][2];

    logic                w_accept;
    logic                w_win_ok;
    logic [PIX_W-1:0]    w_tl, w_tm, w_tr, w_ml, w_mm, w_mr, w_bl, w_bm, w_br;
    logic [SW-1:0]       w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic [SW-1:0]       w_gx_abs, w_gy_abs;
    logic [MW-1:0]       w_mag;
    logic                w_mag_sat;
    logic [GW-1:0]       w_gsum;
    logic [PIX_W-1:0]    w_sobel, w_gauss, w_thr, w_result;

    assign w_accept = (r_state == S_RUN) && validData;
    assign w_win_ok = (r_row >= RW'(2)) && (r_col >= CW'(2));

    // Assemble the full 3x3 window as it will stand after the current pixel is shifted in.
    always_comb begin
        w_tl = r_win[0][1];
        w_tm = r_win[0][0];
        w_tr = r_lb2[r_col];
        w_ml = r_win[1][1];
        w_mm = r_win[1][0];
        w_mr = r_lb1[r_col];
        w_bl = r_win[2][1];
        w_bm = r_win[2][0];
        w_br = pixel_in;
    end

    // Kernel arithmetic: Sobel magnitude, Gaussian sum and the selected clamped result.
    always_comb begin
        w_gx_pos = SW'(w_tr) + (SW'(w_mr) << 1) + SW'(w_br);
        w_gx_neg = SW'(w_tl) + (SW'(w_ml) << 1) + SW'(w_bl);
        w_gy_pos = SW'(w_bl) + (SW'(w_bm) << 1) + SW'(w_br);
        w_gy_neg = SW'(w_tl) + (SW'(w_tm) << 1) + SW'(w_tr);
        w_gx_abs = (w_gx_pos >= w_gx_neg) ? (w_gx_pos - w_gx_neg) : (w_gx_neg - w_gx_pos);
        w_gy_abs = (w_gy_pos >= w_gy_neg) ? (w_gy_pos - w_gy_neg) : (w_gy_neg - w_gy_pos);
        w_mag     = MW'(w_gx_abs) + MW'(w_gy_abs);
        w_mag_sat = |w_mag[MW-1:PIX_W];
        w_sobel   = w_mag_sat ? {PIX_W{1'b1}} : w_mag[PIX_W-1:0];
        w_thr     = (w_mag >= MW'(THRESH)) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
        w_gsum    = GW'(w_tl) + GW'(w_tr) + GW'(w_bl) + GW'(w_br)
                  + (GW'(w_tm) << 1) + (GW'(w_ml) << 1) + (GW'(w_mr) << 1) + (GW'(w_bm) << 1)
                  + (GW'(w_mm) << 2);
        w_gauss   = PIX_W'(w_gsum >> 4);
        case (r_mode)
            2'b00:   w_result = w_mm;
            2'b01:   w_result = w_sobel;
            2'b10:   w_result = w_gauss;
            default: w_result = w_thr;
        endcase
    end

    // Line buffers and window shift on every accepted pixel; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= pixel_in;
            r_win[0][1]  <= r_win[0][0];
            r_win[1][1]  <= r_win[1][0];
            r_win[2][1]  <= r_win[2][0];
            r_win[0][0]  <= w_tr;
            r_win[1][0]  <= w_mr;
            r_win[2][0]  <= pixel_in;
        end
    end

    // Frame FSM with raster counters and registered result/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_oidx  <= '0;
            r_mode  <= 2'b00;
            r_vld   <= 1'b0;
            r_pout  <= '0;
            r_paddr <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_vld  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_mode  <= filter;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_oidx  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (validData) begin
                        if (w_win_ok) begin
                            r_vld   <= 1'b1;
                            r_pout  <= w_result;
                            r_paddr <= r_oidx;
                            r_oidx  <= r_oidx + 1'b1;
                        end
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            if (r_row == ROW_LAST) begin
                                r_state <= S_FLUSH;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ValidResult   = r_vld;
    assign pixel_out     = r_pout;
    assign Pixel_address = r_paddr;
    assign busy          = r_busy;
    assign done          = r_done;

`ifdef CONV3X3_SAT_COUNT_EN
    logic [15:0] r_sat;

    // Count results whose Sobel magnitude had to be clamped (modes 01 and 11), saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_sat <= '0;
        end else if (w_accept && w_win_ok && r_mode[0] && w_mag_sat && (r_sat != 16'hFFFF)) begin
            r_sat <= r_sat + 16'd1;
        end
    end

    assign sat_count = r_sat;
`endif

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream on a 4x4 image with directed and random frames against an arithmetic reference.
// Each pixel step samples outputs 1 time unit after the rising edge.
// Stall cycles are inserted to check that no result appears on a stalled cycle.
module tb_conv3x3_stream;

    localparam int PW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int TH   = 128;
    localparam int MAXV = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    filter = 2'b00;
    logic          validData = 1'b0;
    logic [PW-1:0] pixel_in = '0;
    logic          ValidResult;
    logic [1:0]    Pixel_address;
    logic [PW-1:0] pixel_out;
    logic          busy;
    logic          done;
`ifdef CONV3X3_SAT_COUNT_EN
    logic [15:0]   sat_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int img [H][W];

    conv3x3_stream #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .THRESH(TH)) dut (
        .clk(clk), .rst(rst), .start(start), .filter(filter),
        .validData(validData), .pixel_in(pixel_in),
        .ValidResult(ValidResult), .Pixel_address(Pixel_address),
        .pixel_out(pixel_out), .busy(busy), .done(done)
`ifdef CONV3X3_SAT_COUNT_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Sobel magnitude |Gx|+|Gy| of the window whose bottom-right pixel is (r,c).
    function automatic int ref_mag(input int r, input int c);
        int gx = 0, gy = 0, p;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                p  = img[r-2+i][c-2+j];
                gx += (j - 1) * ((i == 1) ? 2 : 1) * p;
                gy += (i - 1) * ((j == 1) ? 2 : 1) * p;
            end
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return gx + gy;
    endfunction

    function automatic int ref_px(input int mode, input int r, input int c);
        int g = 0, m;
        m = ref_mag(r, c);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                g += ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1) * img[r-2+i][c-2+j];
        case (mode)
            0:       return img[r-1][c-1];
            1:       return (m > MAXV) ? MAXV : m;
            2:       return g / 16;
            default: return (m >= TH) ? MAXV : 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gap_mode: 0 continuous, 1 alternate stall cycles, 2 random stalls.
    // mid_start/end_start pulse start during RUN / together with the last pixel.
    task automatic run_frame(input int mode, input int gap_mode, input bit mid_start, input bit end_start);
        int  exp_addr = 0;
        int  exp_sat  = 0;
        bit  last, gap;
        start  = 1'b1;
        filter = 2'(mode);
        step();
        start  = 1'b0;
        check("busy_after_start", int'(busy), 1);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                last      = (r == H - 1) && (c == W - 1);
                validData = 1'b1;
                pixel_in  = PW'(img[r][c]);
                start     = (mid_start && r == 1 && c == 1) || (end_start && last);
                filter    = 2'(mode + 1);
                step();
                validData = 1'b0;
                start     = 1'b0;
                if (r >= 2 && c >= 2) begin
                    check("valid_on_window", int'(ValidResult), 1);
                    check("pixel_out", int'(pixel_out), ref_px(mode, r, c));
                    check("pixel_address", int'(Pixel_address), exp_addr);
                    exp_addr++;
                    if ((mode == 1 || mode == 3) && ref_mag(r, c) > MAXV) exp_sat++;
                end else begin
                    check("valid_on_border", int'(ValidResult), 0);
                end
                gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
                if (gap && !last) begin
                    pixel_in = PW'($urandom_range(0, MAXV));
                    step();
                    check("valid_on_stall", int'(ValidResult), 0);
                end
            end
        end
        check("busy_in_flush", int'(busy), 1);
        step();
        check("done_pulse", int'(done), 1);
        check("busy_in_done", int'(busy), 0);
        check("valid_after_flush", int'(ValidResult), 0);
        step();
        check("done_single", int'(done), 0);
        check("busy_idle", int'(busy), 0);
`ifdef CONV3X3_SAT_COUNT_EN
        check("sat_count", int'(sat_count), exp_sat);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(ValidResult), 0);
        check({tag, "_pixel_out"}, int'(pixel_out), 0);
        check({tag, "_addr"}, int'(Pixel_address), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #12;
        check_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();

        // validData while idle must be ignored
        validData = 1'b1;
        pixel_in  = 8'd77;
        step();
        step();
        validData = 1'b0;
        check("idle_valid", int'(ValidResult), 0);
        check("idle_busy", int'(busy), 0);

        // Constant 100 image: pass, Gaussian, Sobel
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
        run_frame(0, 0, 1'b0, 1'b0);
        run_frame(2, 0, 1'b0, 1'b0);
        run_frame(1, 0, 1'b0, 1'b0);

        // Vertical edge 0,0,255,255: clamped Sobel and threshold
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 2) ? 255 : 0;
        run_frame(1, 0, 1'b0, 1'b0);
        run_frame(3, 0, 1'b0, 1'b0);

        // Ramp col*10: magnitude 80 stays below threshold
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = c * 10;
        run_frame(3, 0, 1'b0, 1'b0);

        // Constant image with alternating stalls
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
        run_frame(0, 1, 1'b0, 1'b0);

        // Reset after 7 pixels, then a fresh frame with start pulses during RUN and on the last pixel
        start  = 1'b1;
        filter = 2'b01;
        step();
        start  = 1'b0;
        for (int k = 0; k < 7; k++) begin
            validData = 1'b1;
            pixel_in  = PW'($urandom_range(0, MAXV));
            step();
            check("pre_reset_valid", int'(ValidResult), 0);
        end
        validData = 1'b0;
        rst = 1'b1;
        #2;
        check_reset_outputs("midframe_reset");
        step();
        rst = 1'b0;
        check("no_done_after_reset", int'(done), 0);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, MAXV);
        run_frame(0, 0, 1'b1, 1'b1);

        // Random images, all modes, random stalls
        for (int f = 0; f < 8; f++) begin
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, MAXV);
            run_frame(f % 4, 2, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
